// File: rtl/clock_time_counter_pkg.sv
// Shared definitions for the time-of-day core: set-mode encodings and BCD digit width.
package clock_time_counter_pkg;
  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_MIN  = 2'd1,
    SET_HOUR = 2'd2
  } mode_t;
endpackage

// File: rtl/clock_time_counter_bcd.sv
// Two-digit BCD counter that wraps to 00 after MAX_VAL; wrap flags the incrementing step that wraps.
module bcd_mod_counter
  import clock_time_counter_pkg::*;
#(
  parameter int MAX_VAL = 59
) (
  input  logic               ck,
  input  logic               reset,
  input  logic               inc,
  output logic [DIGIT_W-1:0] units,
  output logic [DIGIT_W-1:0] tens,
  output logic               wrap
);
  localparam logic [DIGIT_W-1:0] MAX_UNITS = DIGIT_W'(MAX_VAL % 10);
  localparam logic [DIGIT_W-1:0] MAX_TENS  = DIGIT_W'(MAX_VAL / 10);

  logic at_max;

  assign at_max = (tens == MAX_TENS) && (units == MAX_UNITS);
  assign wrap   = inc && at_max;

  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      units <= '0;
      tens  <= '0;
    end else if (inc) begin
      if (at_max) begin
        units <= '0;
        tens  <= '0;
      end else if (units == DIGIT_W'(9)) begin
        units <= '0;
        tens  <= tens + DIGIT_W'(1);
      end else begin
        units <= units + DIGIT_W'(1);
      end
    end
  end
endmodule

// File: rtl/clock_time_counter.sv
// Time-of-day core: counts minute strobes into BCD hh:mm, with a button-driven set mode.
module clock_time_counter
  import clock_time_counter_pkg::*;
#(
  parameter int HOUR_MAX = 23,
  parameter int MIN_MAX  = 59
) (
  input  logic               ck,
  input  logic               reset,
  input  logic               min_hit,
  input  logic               btn_mode,
  input  logic               btn_inc,
  output logic [DIGIT_W-1:0] min_units,
  output logic [DIGIT_W-1:0] min_tens,
  output logic [DIGIT_W-1:0] hour_units,
  output logic [DIGIT_W-1:0] hour_tens,
  output logic [1:0]         mode,
  output logic               day_wrap
);
  mode_t state;
  logic  mode_q, inc_q, armed;
  logic  mode_ev, inc_ev;
  logic  min_inc, hour_inc, min_wrap, hour_wrap;

  // armed stays low for the first edge after reset so a button held through release is not an event
  assign mode_ev = armed && btn_mode && !mode_q;
  assign inc_ev  = armed && btn_inc && !inc_q;
  assign mode    = state;

  always_comb begin
    min_inc  = 1'b0;
    hour_inc = 1'b0;
    case (state)
      RUN: begin
        min_inc  = min_hit;
        hour_inc = min_hit && min_wrap;
      end
      SET_MIN:  min_inc  = inc_ev && !mode_ev;
      SET_HOUR: hour_inc = inc_ev && !mode_ev;
      default: ;
    endcase
  end

  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      state    <= RUN;
      mode_q   <= 1'b0;
      inc_q    <= 1'b0;
      armed    <= 1'b0;
      day_wrap <= 1'b0;
    end else begin
      armed    <= 1'b1;
      mode_q   <= btn_mode;
      inc_q    <= btn_inc;
      day_wrap <= (state == RUN) && hour_wrap;
      case (state)
        RUN:      if (mode_ev) state <= SET_MIN;
        SET_MIN:  if (mode_ev) state <= SET_HOUR;
        SET_HOUR: if (mode_ev) state <= RUN;
        default:  state <= RUN;
      endcase
    end
  end

  bcd_mod_counter #(.MAX_VAL(MIN_MAX)) u_min (
    .ck    (ck),
    .reset (reset),
    .inc   (min_inc),
    .units (min_units),
    .tens  (min_tens),
    .wrap  (min_wrap)
  );

  bcd_mod_counter #(.MAX_VAL(HOUR_MAX)) u_hour (
    .ck    (ck),
    .reset (reset),
    .inc   (hour_inc),
    .units (hour_units),
    .tens  (hour_tens),
    .wrap  (hour_wrap)
  );
endmodule
